// File: rtl/ysyx_25060173_pkg.sv
// Shared decode/ALU definitions: one-hot alu_op bit positions, RV32I opcode and
// funct fields, and the registered decode entry carried from IDU to execute.
package ysyx_25060173_pkg;

    localparam int ALU_OP_W = 13;

    localparam int OP_ADDI  = 0;
    localparam int OP_AUIPC = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;
    localparam int OP_AND   = 4;
    localparam int OP_BNE   = 5;
    localparam int OP_BGE   = 6;
    localparam int OP_BGEU  = 7;
    localparam int OP_BLT   = 8;
    localparam int OP_BLTU  = 9;
    localparam int OP_BEQ   = 10;
    localparam int OP_SLTIU = 11;
    localparam int OP_SLLI  = 12;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic [31:0]         alu_src1;
        logic [31:0]         alu_src2;
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         pc;
        logic [31:0]         imm;
        logic [4:0]          rd_addr;
        logic                rd_wen;
        logic                is_branch;
        logic                illegal;
    } idu_entry_t;

    function automatic logic [ALU_OP_W-1:0] op_bit(input int idx);
        return {{(ALU_OP_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/ysyx_25060173_idu_dec.sv
// Combinational RV32I subset decoder: builds one idu_entry_t from the
// instruction word, its pc and the register-file read data.
module ysyx_25060173_idu_dec
    import ysyx_25060173_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output idu_entry_t  entry
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic        legal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};

    always_comb begin
        entry         = '0;
        legal         = 1'b0;
        entry.pc      = pc;
        entry.rd_addr = inst[11:7];
        case (opcode)
            OPC_OP_IMM: begin
                entry.alu_src1 = rs1_data;
                entry.alu_src2 = imm_i;
                entry.imm      = imm_i;
                case (funct3)
                    F3_ADD_SUB: begin entry.alu_op = op_bit(OP_ADDI);  legal = 1'b1; end
                    F3_SLTU:    begin entry.alu_op = op_bit(OP_SLTIU); legal = 1'b1; end
                    F3_SLL: begin
                        // inst[25] set would be a 6-bit RV64 shamt, not valid here
                        if (funct7 == F7_BASE) begin
                            entry.alu_op   = op_bit(OP_SLLI);
                            entry.alu_src2 = {27'b0, inst[24:20]};
                            legal          = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_AUIPC: begin
                entry.alu_src1 = pc;
                entry.alu_src2 = imm_u;
                entry.imm      = imm_u;
                entry.alu_op   = op_bit(OP_AUIPC);
                legal          = 1'b1;
            end
            OPC_OP: begin
                entry.alu_src1 = rs1_data;
                entry.alu_src2 = rs2_data;
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    entry.alu_op = op_bit(OP_ADD); legal = 1'b1;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                    entry.alu_op = op_bit(OP_SUB); legal = 1'b1;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    entry.alu_op = op_bit(OP_AND); legal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                entry.alu_src1  = rs1_data;
                entry.alu_src2  = rs2_data;
                entry.imm       = imm_b;
                entry.is_branch = 1'b1;
                legal           = 1'b1;
                case (funct3)
                    F3_BEQ:  entry.alu_op = op_bit(OP_BEQ);
                    F3_BNE:  entry.alu_op = op_bit(OP_BNE);
                    F3_BLT:  entry.alu_op = op_bit(OP_BLT);
                    F3_BGE:  entry.alu_op = op_bit(OP_BGE);
                    F3_BLTU: entry.alu_op = op_bit(OP_BLTU);
                    F3_BGEU: entry.alu_op = op_bit(OP_BGEU);
                    default: legal = 1'b0;
                endcase
            end
            default: ;
        endcase

        // Illegal entries still flow downstream but carry no operation or operands
        if (!legal) begin
            entry.alu_src1  = '0;
            entry.alu_src2  = '0;
            entry.imm       = '0;
            entry.alu_op    = '0;
            entry.is_branch = 1'b0;
        end
        entry.illegal = ~legal;
        entry.rd_wen  = legal & ~entry.is_branch & (inst[11:7] != 5'd0);
    end

endmodule

// File: rtl/ysyx_25060173_idu.sv
// Instruction decode stage: valid/ready handshake around the decoder.
// Define YSYX_25060173_IDU_SKID_EN for a skid slot that registers in_ready.
module ysyx_25060173_idu
    import ysyx_25060173_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [31:0]         in_pc,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    input  logic [31:0]         rs1_data,
    input  logic [31:0]         rs2_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         alu_src1,
    output logic [31:0]         alu_src2,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_imm,
    output logic [4:0]          rd_addr,
    output logic                rd_wen,
    output logic                is_branch,
    output logic                illegal
);

    idu_entry_t dec_entry;
    idu_entry_t out_reg;
    idu_entry_t out_next;
    logic       out_valid_reg;
    logic       out_valid_next;
    logic       accept;

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    ysyx_25060173_idu_dec u_dec (
        .inst     (in_inst),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .entry    (dec_entry)
    );

    assign accept = in_valid & in_ready;

`ifdef YSYX_25060173_IDU_SKID_EN
    idu_entry_t skid_reg;
    idu_entry_t skid_next;
    logic       skid_valid_reg;
    logic       skid_valid_next;

    // Ready depends only on skid occupancy (and flush), never on out_ready
    assign in_ready = ~skid_valid_reg & ~flush;

    always_comb begin
        out_next        = out_reg;
        out_valid_next  = out_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (~out_valid_reg | out_ready) begin
            if (skid_valid_reg) begin
                out_next        = skid_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_next       = dec_entry;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = dec_entry;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            skid_reg       <= skid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end
`else
    assign in_ready = (~out_valid_reg | out_ready) & ~flush;

    always_comb begin
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (accept) begin
            out_next       = dec_entry;
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign alu_src1  = out_reg.alu_src1;
    assign alu_src2  = out_reg.alu_src2;
    assign alu_op    = out_reg.alu_op;
    assign out_pc    = out_reg.pc;
    assign out_imm   = out_reg.imm;
    assign rd_addr   = out_reg.rd_addr;
    assign rd_wen    = out_reg.rd_wen;
    assign is_branch = out_reg.is_branch;
    assign illegal   = out_reg.illegal;

endmodule

// File: tb/tb_ysyx_25060173_idu.sv
// Directed bench for ysyx_25060173_idu: decode vectors, stall, flush and reset.
module tb_ysyx_25060173_idu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [12:0] alu_op;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        is_branch;
    logic        illegal;

    int checks   = 0;
    int failures = 0;
    bit accepted;
    bit exp_rdy;

    always #5 clk = ~clk;

    ysyx_25060173_idu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .alu_op    (alu_op),
        .out_pc    (out_pc),
        .out_imm   (out_imm),
        .rd_addr   (rd_addr),
        .rd_wen    (rd_wen),
        .is_branch (is_branch),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        rs1_data = d1;
        rs2_data = d2;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_alu_op", {19'b0, alu_op}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_rd_wen", {31'b0, rd_wen}, 32'd0);
        tick; tick;
        @(negedge clk); rst_n = 1'b1;
        tick;
        $display("step reset released");

        send(32'h00500093, 32'h80000000, 32'd0, 32'd0);
        #1;
        check("addi_in_ready", {31'b0, in_ready}, 32'd1);
        check("addi_rs1_addr", {27'b0, rs1_addr}, 32'd0);
        tick;
        check("addi_valid", {31'b0, out_valid}, 32'd1);
        check("addi_op", {19'b0, alu_op}, 32'h0001);
        check("addi_src1", alu_src1, 32'd0);
        check("addi_src2", alu_src2, 32'd5);
        check("addi_rd", {27'b0, rd_addr}, 32'd1);
        check("addi_wen", {31'b0, rd_wen}, 32'd1);
        $display("step addi x1,x0,5");

        send(32'h00208463, 32'h80000004, 32'd7, 32'd7);
        #1;
        check("beq_rs1_addr", {27'b0, rs1_addr}, 32'd1);
        check("beq_rs2_addr", {27'b0, rs2_addr}, 32'd2);
        tick;
        check("beq_op", {19'b0, alu_op}, 32'h0400);
        check("beq_src1", alu_src1, 32'd7);
        check("beq_src2", alu_src2, 32'd7);
        check("beq_imm", out_imm, 32'd8);
        check("beq_branch", {31'b0, is_branch}, 32'd1);
        check("beq_wen", {31'b0, rd_wen}, 32'd0);
        check("beq_pc", out_pc, 32'h80000004);
        $display("step beq x1,x2,8");

        send(32'h12345117, 32'h80000000, 32'hdead0000, 32'd0);
        tick;
        check("auipc_op", {19'b0, alu_op}, 32'h0002);
        check("auipc_src1", alu_src1, 32'h80000000);
        check("auipc_src2", alu_src2, 32'h12345000);
        check("auipc_imm", out_imm, 32'h12345000);
        check("auipc_rd", {27'b0, rd_addr}, 32'd2);
        check("auipc_branch", {31'b0, is_branch}, 32'd0);
        $display("step auipc x2,0x12345");

        send(32'h00000000, 32'h80000008, 32'd1, 32'd2);
        tick;
        check("zero_valid", {31'b0, out_valid}, 32'd1);
        check("zero_illegal", {31'b0, illegal}, 32'd1);
        check("zero_op", {19'b0, alu_op}, 32'd0);
        check("zero_wen", {31'b0, rd_wen}, 32'd0);
        $display("step illegal 0x00000000");

        send(32'h40208133, 32'h8000000c, 32'd10, 32'd3);
        tick;
        check("sub_op", {19'b0, alu_op}, 32'h0008);
        check("sub_src1", alu_src1, 32'd10);
        check("sub_src2", alu_src2, 32'd3);
        check("sub_imm", out_imm, 32'd0);
        check("sub_illegal", {31'b0, illegal}, 32'd0);
        $display("step sub x2,x1,x2");

        send(32'h00409193, 32'h80000010, 32'd9, 32'd0);
        tick;
        check("slli_op", {19'b0, alu_op}, 32'h1000);
        check("slli_src2", alu_src2, 32'd4);
        check("slli_rd", {27'b0, rd_addr}, 32'd3);
        $display("step slli x3,x1,4");

        send(32'h02409193, 32'h80000014, 32'd9, 32'd0);
        tick;
        check("slli25_illegal", {31'b0, illegal}, 32'd1);
        check("slli25_op", {19'b0, alu_op}, 32'd0);
        check("slli25_wen", {31'b0, rd_wen}, 32'd0);
        $display("step slli with inst[25]=1");

        send(32'hfff13093, 32'h80000018, 32'd4, 32'd0);
        tick;
        check("sltiu_op", {19'b0, alu_op}, 32'h0800);
        check("sltiu_src2", alu_src2, 32'hffffffff);
        check("sltiu_imm", out_imm, 32'hffffffff);
        $display("step sltiu x1,x2,-1");

        send(32'h00000013, 32'h8000001c, 32'd0, 32'd0);
        tick;
        check("nop_op", {19'b0, alu_op}, 32'h0001);
        check("nop_wen", {31'b0, rd_wen}, 32'd0);
        $display("step addi x0 (nop)");

        send(32'h002082b3, 32'h80000020, 32'd1, 32'd2);
        tick;
        check("add_op", {19'b0, alu_op}, 32'h0004);
        check("add_rd", {27'b0, rd_addr}, 32'd5);
        $display("step add x5,x1,x2");

        send(32'h0020f333, 32'h80000024, 32'd5, 32'd6);
        out_ready = 1'b0;
        accepted  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
`ifdef YSYX_25060173_IDU_SKID_EN
            exp_rdy = (i == 0);
`else
            exp_rdy = 1'b0;
`endif
            check("stall_in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            if (in_valid && in_ready) accepted = 1'b1;
            tick;
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_op_held", {19'b0, alu_op}, 32'h0004);
            check("stall_rd_held", {27'b0, rd_addr}, 32'd5);
            if (accepted) in_valid = 1'b0;
            $display("step stall cycle %0d in_ready=%0b", i, in_ready);
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        check("unstall_valid", {31'b0, out_valid}, 32'd1);
        check("unstall_op", {19'b0, alu_op}, 32'h0010);
        check("unstall_src1", alu_src1, 32'd5);
        check("unstall_src2", alu_src2, 32'd6);
        tick;
        check("no_dup_valid", {31'b0, out_valid}, 32'd0);
        $display("step and x6 delivered once after stall");

        send(32'h00500093, 32'h80000028, 32'd0, 32'd0);
        out_ready = 1'b0;
        tick;
        check("pre_flush_valid", {31'b0, out_valid}, 32'd1);
        send(32'h40208133, 32'h8000002c, 32'd10, 32'd3);
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        tick;
        check("flush_gone", {31'b0, out_valid}, 32'd0);
        $display("step flush with in_valid");

        send(32'h12345117, 32'h80000030, 32'd0, 32'd0);
        tick;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_src1", alu_src1, 32'd0);
        check("async_rst_pc", out_pc, 32'd0);
        tick;
        check("held_rst_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick;
        check("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_op", {19'b0, alu_op}, 32'h0002);
        in_valid = 1'b0;
        $display("step async reset mid-transfer");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

endmodule
